// File: rtl/counter_seq_pkg.sv
// Shared types and default widths for the counter sequencer.
package counter_seq_pkg;
    localparam int DEF_WIDTH  = 4;
    localparam int DEF_REPS_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, HOLD, FINISH} seq_state_t;
endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Control/status bundle between the sequencer and the logic driving it.
interface counter_seq_ctrl_if
    import counter_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int REPS_W = DEF_REPS_W
);
    logic              start;
    logic              pause;
    logic              abort;
    logic [WIDTH-1:0]  term_val;
    logic [REPS_W-1:0] reps;
    logic [WIDTH-1:0]  count;
    logic [REPS_W-1:0] rep_cnt;
    logic              wrap;
    logic              busy;
    logic              done;

    modport master (
        output start, pause, abort, term_val, reps,
        input  count, rep_cnt, wrap, busy, done
    );

    modport slave (
        input  start, pause, abort, term_val, reps,
        output count, rep_cnt, wrap, busy, done
    );
endinterface

// File: rtl/counter_mod_n.sv
// Modulo counter 0..term; clr beats en, wrap flags the enabled terminal cycle.
module counter_mod_n #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    assign wrap = en && (count == term);

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en)
            count <= wrap ? '0 : count + WIDTH'(1);
    end
endmodule

// File: rtl/counter_seq_ctrl.sv
// Runs counter_mod_n through 0..term_q for reps_q periods with pause/abort.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int REPS_W = DEF_REPS_W
) (
    input logic               clk,
    input logic               rst,
    counter_seq_ctrl_if.slave bus
);
    seq_state_t        state;
    logic [WIDTH-1:0]  term_q;
    logic [REPS_W-1:0] reps_q;
    logic [REPS_W-1:0] rep_cnt;
    logic [WIDTH-1:0]  count;
    logic              en;
    logic              clr;
    logic              wrap;

    // pause gates counting in the same cycle, before the FSM has moved to HOLD
    assign en  = ((state == RUN) || (state == HOLD)) && !bus.pause;
    assign clr = rst || bus.abort || (state == IDLE);

    counter_mod_n #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (clr),
        .term  (term_q),
        .count (count),
        .wrap  (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            state   <= IDLE;
            term_q  <= '0;
            reps_q  <= '0;
            rep_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rep_cnt <= '0;
                    if (bus.start) begin
                        term_q <= bus.term_val;
                        reps_q <= bus.reps;
                        state  <= (bus.reps == '0) ? FINISH : RUN;
                    end
                end
                RUN, HOLD: begin
                    if (bus.pause) begin
                        state <= HOLD;
                    end else begin
                        state <= RUN;
                        if (wrap) begin
                            rep_cnt <= rep_cnt + REPS_W'(1);
                            if (rep_cnt == reps_q - REPS_W'(1))
                                state <= FINISH;
                        end
                    end
                end
                // clear here so rep_cnt already reads 0 in the following IDLE cycle
                FINISH: begin
                    rep_cnt <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.count   = count;
    assign bus.rep_cnt = rep_cnt;
    assign bus.wrap    = wrap;
    assign bus.busy    = (state == RUN) || (state == HOLD);
    assign bus.done    = (state == FINISH);
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: vector table, corner sequences, random vs. run-position model.
module tb_counter_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;

    counter_seq_ctrl_if #(.WIDTH(4), .REPS_W(4)) bus ();

    counter_seq_ctrl #(.WIDTH(4), .REPS_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic r, s, p, a;
        int   tv, rp;
        int   cnt, rep, w, b, d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic r, logic s, logic p, logic a, int tv, int rp,
                                 int cnt, int rep, int w, int b, int d);
        vec_t v;
        v.r = r; v.s = s; v.p = p; v.a = a; v.tv = tv; v.rp = rp;
        v.cnt = cnt; v.rep = rep; v.w = w; v.b = b; v.d = d;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    endtask

    task automatic chk_all(input string tag, input int c, input int rep, input int w,
                           input int b, input int d);
        chk({tag, ".count"},   int'(bus.count),   c);
        chk({tag, ".rep_cnt"}, int'(bus.rep_cnt), rep);
        chk({tag, ".wrap"},    int'(bus.wrap),    w);
        chk({tag, ".busy"},    int'(bus.busy),    b);
        chk({tag, ".done"},    int'(bus.done),    d);
    endtask

    task automatic drive(input logic r, input logic s, input logic p, input logic a,
                         input int tv, input int rp);
        rst          = r;
        bus.start    = s;
        bus.pause    = p;
        bus.abort    = a;
        bus.term_val = 4'(tv);
        bus.reps     = 4'(rp);
    endtask

    // drive one cycle's inputs, check that cycle's outputs mid-cycle, then advance
    task automatic step(input string tag, input logic r, input logic s, input logic p,
                        input logic a, input int tv, input int rp,
                        input int c, input int rep, input int w, input int b, input int d);
        drive(r, s, p, a, tv, rp);
        @(negedge clk);
        chk_all(tag, c, rep, w, b, d);
        @(posedge clk);
        #1;
    endtask

    // reference model: a run is a position t in enabled cycles since start
    int m_phase, m_t, m_T, m_R;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        @(posedge clk); #1;
        step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);

        // term=2 reps=3, with ignored starts during RUN and FINISH, then reps=0
        vecs.push_back(mkv(0, 1, 0, 0, 2, 3, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 1, 0, 0, 9, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 2, 1, 1, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 2, 2, 1, 1, 0));
        vecs.push_back(mkv(0, 1, 0, 0, 7, 1, 0, 3, 0, 0, 1));
        vecs.push_back(mkv(0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (vecs[i])
            step($sformatf("vec%0d", i), vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].a,
                 vecs[i].tv, vecs[i].rp, vecs[i].cnt, vecs[i].rep, vecs[i].w,
                 vecs[i].b, vecs[i].d);

        // basic run: term=13 reps=1, done in cycle 15
        step("basic0", 0, 1, 0, 0, 13, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++)
            step($sformatf("basic%0d", k), 0, 0, 0, 0, 0, 0,
                 (k <= 14) ? k - 1 : 0, (k == 15) ? 1 : 0,
                 int'(k == 14), int'(k <= 14), int'(k == 15));

        // pause held 4 cycles on the terminal count 5
        step("pause0", 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 12; k++)
            step($sformatf("pause%0d", k), 0, 0, (k >= 6 && k <= 9), 0, 0, 0,
                 (k <= 5) ? k - 1 : ((k <= 10) ? 5 : 0), (k == 11) ? 1 : 0,
                 int'(k == 10), int'(k <= 10), int'(k == 11));

        // abort at count 7, then immediate term=0 reps=2 run
        step("abort0", 0, 1, 0, 0, 13, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++)
            step($sformatf("abort%0d", k), 0, 0, 0, 0, 0, 0, k - 1, 0, 0, 1, 0);
        step("abort8",  0, 0, 0, 1, 0, 0, 7, 0, 0, 1, 0);
        step("abort9",  0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        step("abort10", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("abort11", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        step("abort12", 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1);
        step("abort13", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset mid-run
        step("rstrun0", 0, 1, 0, 0, 9, 2, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++)
            step($sformatf("rstrun%0d", k), 0, 0, 0, 0, 0, 0, k - 1, 0, 0, 1, 0);
        step("rstrun4", 1, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0);
        step("rstrun5", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // random traffic against the model
        m_phase = 0; m_t = 0; m_T = 0; m_R = 0;
        for (int i = 0; i < 2500; i++) begin
            logic r, s, p, a;
            int   tv, rp, ec, er, ew;
            r  = ($urandom_range(0, 199) == 0);
            a  = ($urandom_range(0, 49) == 0);
            s  = ($urandom_range(0, 4) == 0);
            p  = ($urandom_range(0, 4) == 0);
            tv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                             : int'($urandom_range(0, 3));
            rp = int'($urandom_range(0, 3));
            drive(r, s, p, a, tv, rp);
            ec = (m_phase == 1) ? m_t % (m_T + 1) : 0;
            er = (m_phase == 1) ? m_t / (m_T + 1) : ((m_phase == 2) ? m_R : 0);
            ew = int'(m_phase == 1 && !p && (m_t % (m_T + 1) == m_T));
            @(negedge clk);
            chk_all("rnd", ec, er, ew, int'(m_phase == 1), int'(m_phase == 2));
            @(posedge clk);
            if (r || a) begin
                m_phase = 0; m_t = 0;
            end else if (m_phase == 0) begin
                if (s) begin
                    m_T = tv; m_R = rp; m_t = 0;
                    m_phase = (rp == 0) ? 2 : 1;
                end
            end else if (m_phase == 1) begin
                if (!p) begin
                    m_t++;
                    if (m_t == (m_T + 1) * m_R) m_phase = 2;
                end
            end else begin
                m_phase = 0; m_t = 0;
            end
            #1;
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Controller that sequences a programmable modulo counter. On a start pulse it latches a terminal count and a repetition count, runs the counter through `0..term` the requested number of times, and supports pause and abort. It reports each wrap and signals completion. It sits between control logic and a `counter_mod_n` datapath instance. It is the generalised, software-controlled form of the fixed 0-to-13 counter.

## Interface
Parameters:
- `WIDTH`, 4: counter width; `term_val` and `count` are this wide.
- `REPS_W`, 4: width of the repetition count.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; accepted only in IDLE.
- `pause`  in  1  level; freezes the run while high.
- `abort`  in  1  pulse; terminates any run with no `done`.
- `term_val`  in  WIDTH  terminal count, latched on an accepted `start`.
- `reps`  in  REPS_W  number of full periods, latched on an accepted `start`.
- `count`  out  WIDTH  current counter value.
- `rep_cnt`  out  REPS_W  number of periods completed in the current run.
- `wrap`  out  1  high in the cycle where `count==term_q` and counting is enabled.
- `busy`  out  1  state is RUN or HOLD.
- `done`  out  1  one-cycle pulse; state is FINISH.

## Operation
- States:
  - IDLE: `count` and `rep_cnt` are held at 0.
  - RUN: counting.
  - HOLD: paused; `count` and `rep_cnt` are frozen.
  - FINISH: lasts one cycle and returns to IDLE.
- Transition priority, highest first: `rst`, then `abort`, then the normal transitions below.
  - `rst` or `abort`: state goes to IDLE; `count`, `rep_cnt`, `term_q`, `reps_q` go to 0.
- IDLE with `start`:
  - Latches `term_q<=term_val` and `reps_q<=reps`.
  - If `reps==0`: next state is FINISH; `done` pulses with no counting.
  - Otherwise: next state is RUN with `count=0`.
- Count enable: `en = (state==RUN || state==HOLD) && !pause`. `pause` takes effect in the same cycle it is high.
- State tracking of `pause`:
  - RUN with `pause` goes to HOLD.
  - HOLD with `!pause` goes to RUN.
- Counting:
  - With `en` and `count!=term_q`: `count` increments by 1.
  - With `en` and `count==term_q`: `wrap=1`, `count<=0`, `rep_cnt<=rep_cnt+1`.
  - If the wrap occurs with `rep_cnt==reps_q-1`, next state is FINISH.
- `term_q==0` is legal: `wrap` asserts on every enabled cycle.
- `pause` high on a terminal cycle suppresses `wrap`; the wrap happens on the first cycle after release.
- `start` outside IDLE is ignored, including during FINISH.
- Inputs `term_val` and `reps` are don't-care except on an accepted `start`.
- `count` never exceeds `term_q`. Arithmetic is unsigned; no overflow is possible.

## Timing
- Reset values: `count=0`, `rep_cnt=0`, `wrap=0`, `busy=0`, `done=0`, state IDLE.
- Outputs:
  - `count`, `rep_cnt`, and state are registered.
  - `wrap`, `busy`, `done` are decoded combinationally from registered values and `pause`.
- Latency:
  - `start` sampled at edge 0: `busy=1` and `count=0` from cycle 1.
  - With no pause, `done` is high in cycle `(term_q+1)*reps_q + 1`; `busy` is 0 in that cycle.
- `abort` sampled at edge k: `busy=0` and `count=0` from cycle k+1; `done` is never asserted for that run.
- Back-to-back runs: the earliest new `start` is accepted in the cycle after FINISH.

## Structure
- Package `counter_seq_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, HOLD, FINISH} seq_state_t`.
  - Default `WIDTH` and `REPS_W` constants.
- Sub-module `counter_mod_n`:
  - Inputs: `clk`, `rst`, `en`, `clr`, `term[WIDTH-1:0]`.
  - Outputs: `count`, `wrap`.
  - `clr` is a synchronous clear with priority over `en`.
- The controller owns the FSM, `term_q`, `reps_q` and `rep_cnt`. It drives `clr` on IDLE, `abort` and `rst`.

## Test plan
- Basic run: `term_val=13`, `reps=1`, start at edge 0.
  - `count` goes 0..13 in cycles 1–14.
  - `wrap` in cycle 14.
  - `done` in cycle 15; `busy` in cycles 1–14 only.
- Repeated run: `term_val=2`, `reps=3`.
  - `count` sequence is 0,1,2 three times.
  - `wrap` in cycles 3, 6 and 9; `rep_cnt` steps 1, 2, 3.
  - `done` in cycle 10.
- Pause:
  - `term_val=5`, `reps=1`; hold `pause` high for 4 cycles while `count==5`.
  - No `wrap` while paused and state is HOLD.
  - `wrap` on the first unpaused cycle; `done` is 4 cycles later than in the unpaused run.
- Abort and restart:
  - Abort at `count=7` (`term_val=13`): next cycle `busy=0` and `count=0`, with no `done`.
  - An immediate `start` with `term_val=0`, `reps=2`: `wrap` in two consecutive cycles, then `done`.
- Edge cases:
  - `reps=0`: `done` in cycle 1 and `busy` never asserts.
  - `start` during RUN is ignored; `term_q` is unchanged.
  - `rst` mid-run: all outputs are 0 the next cycle.
